// File: rtl/vga_frame_scanout.sv
// 800x600 VGA scanout: reads one SRAM word per active pixel from the
// displayed buffer and drives registered RGB333, sync and data-enable.
module vga_frame_scanout #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FRONT  = 56,
    parameter int   H_SYNC   = 120,
    parameter int   H_BACK   = 64,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FRONT  = 37,
    parameter int   V_SYNC   = 6,
    parameter int   V_BACK   = 23,
    parameter logic SYNC_POL = 1'b1,
    parameter int   RD_LAT   = 2,
    parameter int   ADDR_W   = 20,
    parameter int   DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] baseAddress,
    output logic [ADDR_W-1:0] sramAddress,
    output logic              sramReadEn,
    input  logic [DATA_W-1:0] sramData,
    output logic [2:0]        vgaRed,
    output logic [2:0]        vgaGreen,
    output logic [2:0]        vgaBlue,
    output logic              vgaHsync,
    output logic              vgaVsync,
    output logic              vgaDe,
    output logic              paintDone
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_PD   = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [HW-1:0]     hcnt_q, hcnt_d;
    logic [VW-1:0]     vcnt_q, vcnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] lofs_q, lofs_d;
    logic              origin, active, hs_raw, vs_raw, pd_raw;

    logic [RD_LAT-1:0] act_sr_q, hs_sr_q, vs_sr_q;
    logic [8:0]        rgb_q;
    logic              de_q, hs_q, vs_q, pd_q;

    logic unused_data;
    assign unused_data = ^sramData[DATA_W-1:9];

    always_comb begin
        origin = (hcnt_q == '0) && (vcnt_q == '0);
        // The frame's base is taken at the origin and used for that same clock
        base_d = origin ? baseAddress : base_q;
        hcnt_d = hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        lofs_d = lofs_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            if (vcnt_q == V_LAST) begin
                vcnt_d = '0;
                lofs_d = '0;
            end else begin
                vcnt_d = vcnt_q + 1'b1;
                lofs_d = lofs_q + ADDR_W'(H_ACTIVE);
            end
        end
        active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        hs_raw = (hcnt_q >= HS_BEG && hcnt_q < HS_END) ? SYNC_POL : ~SYNC_POL;
        vs_raw = (vcnt_q >= VS_BEG && vcnt_q < VS_END) ? SYNC_POL : ~SYNC_POL;
        pd_raw = (hcnt_q == H_LAST) && (vcnt_q == V_PD);
        sramReadEn  = active & rst;
        sramAddress = sramReadEn ? base_d + lofs_q + ADDR_W'(hcnt_q) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            base_q   <= '0;
            lofs_q   <= '0;
            act_sr_q <= '0;
            hs_sr_q  <= {RD_LAT{~SYNC_POL}};
            vs_sr_q  <= {RD_LAT{~SYNC_POL}};
            rgb_q    <= '0;
            de_q     <= 1'b0;
            hs_q     <= ~SYNC_POL;
            vs_q     <= ~SYNC_POL;
            pd_q     <= 1'b0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            base_q      <= base_d;
            lofs_q      <= lofs_d;
            act_sr_q[0] <= active;
            hs_sr_q[0]  <= hs_raw;
            vs_sr_q[0]  <= vs_raw;
            for (int i = 1; i < RD_LAT; i++) begin
                act_sr_q[i] <= act_sr_q[i-1];
                hs_sr_q[i]  <= hs_sr_q[i-1];
                vs_sr_q[i]  <= vs_sr_q[i-1];
            end
            // sramData now belongs to the address issued RD_LAT clocks ago
            rgb_q <= act_sr_q[RD_LAT-1] ? sramData[8:0] : 9'd0;
            de_q  <= act_sr_q[RD_LAT-1];
            hs_q  <= hs_sr_q[RD_LAT-1];
            vs_q  <= vs_sr_q[RD_LAT-1];
            pd_q  <= pd_raw;
        end
    end

    assign vgaRed    = rgb_q[8:6];
    assign vgaGreen  = rgb_q[5:3];
    assign vgaBlue   = rgb_q[2:0];
    assign vgaHsync  = hs_q;
    assign vgaVsync  = vs_q;
    assign vgaDe     = de_q;
    assign paintDone = pd_q;

endmodule

// File: tb/tb_vga_frame_scanout.sv
// Directed bench for vga_frame_scanout using a shrunken 15x8 raster
// (8x4 active) so several frames fit in a short run.
module tb_vga_frame_scanout;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] baseAddress;
    logic [19:0] sramAddress;
    logic        sramReadEn;
    logic [31:0] sramData;
    logic [2:0]  vgaRed, vgaGreen, vgaBlue;
    logic        vgaHsync, vgaVsync, vgaDe, paintDone;
    logic [31:0] d1, d2;

    always #5 clk = ~clk;

    vga_frame_scanout #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_POL(1'b1), .RD_LAT(2), .ADDR_W(20), .DATA_W(32)
    ) dut (
        .clk(clk), .rst(rst), .baseAddress(baseAddress),
        .sramAddress(sramAddress), .sramReadEn(sramReadEn),
        .sramData(sramData),
        .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
        .vgaHsync(vgaHsync), .vgaVsync(vgaVsync),
        .vgaDe(vgaDe), .paintDone(paintDone)
    );

    // SRAM model: 2-clock latency, junk when not strobed
    always @(posedge clk) begin
        d1 <= sramReadEn ? {12'hABC, sramAddress} : 32'hFFFF_FFFF;
        d2 <= d1;
    end
    assign sramData = d2;

    typedef struct {
        int          cyc;
        logic [19:0] base;
        logic        en;
        logic [19:0] addr;
        logic        de, hs, vs, pd;
        logic [8:0]  rgb;
    } vec_t;

    vec_t tbl[$];
    int   n_run = 0;
    int   n_fail = 0;
    int   idx;
    int   pd_err;

    function automatic logic [33:0] pins();
        return {sramReadEn, sramAddress, vgaDe, vgaHsync, vgaVsync,
                paintDone, vgaRed, vgaGreen, vgaBlue};
    endfunction

    task automatic check(input string name, input logic [33:0] exp);
        n_run++;
        if (pins() !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, pins(), exp);
        end
    endtask

    function automatic void add(int c, logic [19:0] b, logic en,
                                logic [19:0] a, logic de, logic hs,
                                logic vs, logic pd, logic [8:0] rgb);
        tbl.push_back('{c, b, en, a, de, hs, vs, pd, rgb});
    endfunction

    localparam logic [19:0] B1 = 20'hFFFF0;

    initial begin
        rst = 1'b0;
        baseAddress = '0;
        //  cyc  base  en addr       de hs vs pd rgb
        add(0,   0,    1, 0,         0, 0, 0, 0, 0);
        add(2,   0,    1, 2,         0, 0, 0, 0, 0);
        add(3,   0,    1, 3,         1, 0, 0, 0, 0);
        add(7,   0,    1, 7,         1, 0, 0, 0, 4);
        add(8,   0,    0, 0,         1, 0, 0, 0, 5);
        add(10,  0,    0, 0,         1, 0, 0, 0, 7);
        add(11,  0,    0, 0,         0, 0, 0, 0, 0);
        add(12,  0,    0, 0,         0, 0, 0, 0, 0);
        add(13,  0,    0, 0,         0, 1, 0, 0, 0);
        add(15,  0,    1, 8,         0, 1, 0, 0, 0);
        add(16,  0,    1, 9,         0, 0, 0, 0, 0);
        add(31,  B1,   1, 17,        0, 0, 0, 0, 0);
        add(45,  B1,   1, 24,        0, 1, 0, 0, 0);
        add(52,  B1,   1, 31,        1, 0, 0, 0, 9'h01C);
        add(53,  B1,   0, 0,         1, 0, 0, 0, 9'h01D);
        add(55,  B1,   0, 0,         1, 0, 0, 0, 9'h01F);
        add(59,  B1,   0, 0,         0, 1, 0, 0, 0);
        add(60,  B1,   0, 0,         0, 1, 0, 1, 0);
        add(61,  B1,   0, 0,         0, 0, 0, 0, 0);
        add(77,  B1,   0, 0,         0, 0, 0, 0, 0);
        add(78,  B1,   0, 0,         0, 0, 1, 0, 0);
        add(107, B1,   0, 0,         0, 0, 1, 0, 0);
        add(108, B1,   0, 0,         0, 0, 0, 0, 0);
        add(120, B1,   1, 20'hFFFF0, 0, 1, 0, 0, 0);
        add(121, B1,   1, 20'hFFFF1, 0, 0, 0, 0, 0);
        add(123, B1,   1, 20'hFFFF3, 1, 0, 0, 0, 9'h1F0);
        add(135, B1,   1, 20'hFFFF8, 0, 1, 0, 0, 0);
        add(150, B1,   1, 20'h00000, 0, 1, 0, 0, 0);
        add(151, B1,   1, 1,         0, 0, 0, 0, 0);
        add(153, B1,   1, 3,         1, 0, 0, 0, 0);
        add(179, B1,   0, 0,         0, 1, 0, 0, 0);
        add(180, B1,   0, 0,         0, 1, 0, 1, 0);
        add(260, 20'h64, 1, 20'hFFFFD, 1, 0, 0, 0, 9'h1FA);

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idx = 0;
        for (int c = 0; c <= 260; c++) begin
            @(negedge clk);
            if (idx < tbl.size() && tbl[idx].cyc == c) begin
                check($sformatf("cyc%0d", c),
                      {tbl[idx].en, tbl[idx].addr, tbl[idx].de,
                       tbl[idx].hs, tbl[idx].vs, tbl[idx].pd,
                       tbl[idx].rgb});
                baseAddress = tbl[idx].base;
                idx++;
            end
        end
        n_run++;
        if (idx != tbl.size()) begin
            n_fail++;
            $display("FAIL table_reach: got %0d want %0d", idx, tbl.size());
        end

        // Asynchronous reset in the middle of an active line
        #1 rst = 1'b0;
        #1 check("rst_async", 34'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("restart_c0", {1'b1, 20'h00064, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000});
        pd_err = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (paintDone !== (c == 60)) pd_err++;
            if (c == 3)
                check("restart_px", {1'b1, 20'h00067, 1'b1, 1'b0, 1'b0,
                                     1'b0, 9'h064});
        end
        n_run++;
        if (pd_err != 0) begin
            n_fail++;
            $display("FAIL restart_pd: got %0d bad cycles want 0", pd_err);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
